// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith ALU plus a multi-cycle
// radix-2 restoring divider for DIV/DIVU that stalls the pipeline while busy.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  waddr_reg_i,
  input  logic        we_reg_i,
  input  logic        flush_i,
  output logic [4:0]  waddr_reg_o,
  output logic        we_reg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  localparam int CW = $clog2(DIV_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_DONE} div_state_t;

  div_state_t  r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_dividend, r_divisor, r_rem, r_hi, r_lo;
  logic        r_neg_q, r_neg_r;

  logic [31:0] w_logic, w_shift, w_arith, w_wdata;
  logic        w_stall, w_whilo;

  // ALU result, selected by result class
  always_comb begin
    w_logic = 32'h0;
    w_shift = 32'h0;
    w_arith = 32'h0;
    case (aluop_i)
      EXE_OR_OP:   w_logic = reg1_i | reg2_i;
      EXE_AND_OP:  w_logic = reg1_i & reg2_i;
      EXE_XOR_OP:  w_logic = reg1_i ^ reg2_i;
      EXE_NOR_OP:  w_logic = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  w_shift = reg2_i << reg1_i[4:0];
      EXE_SRL_OP:  w_shift = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP:  w_shift = $signed(reg2_i) >>> reg1_i[4:0];
      EXE_ADDU_OP: w_arith = reg1_i + reg2_i;
      EXE_SUBU_OP: w_arith = reg1_i - reg2_i;
      EXE_SLT_OP:  w_arith = {31'h0, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: w_arith = {31'h0, reg1_i < reg2_i};
      default: ;
    endcase
    w_wdata = 32'h0;
    case (alusel_i)
      EXE_RES_LOGIC: w_wdata = w_logic;
      EXE_RES_SHIFT: w_wdata = w_shift;
      EXE_RES_ARITH: w_wdata = w_arith;
      default:       w_wdata = 32'h0;
    endcase
  end

  logic        w_is_div, w_signed, w_take, w_last;
  logic [31:0] w_abs1, w_abs2, w_rem_step, w_quot_step;
  logic [32:0] w_trial;

  assign w_is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign w_signed = (aluop_i == EXE_DIV_OP);
  assign w_abs1   = (w_signed && reg1_i[31]) ? -reg1_i : reg1_i;
  assign w_abs2   = (w_signed && reg2_i[31]) ? -reg2_i : reg2_i;

  // One restoring step: the dividend register shifts out its MSB and
  // shifts in the new quotient bit, so after the last step it holds the quotient.
  assign w_trial     = {r_rem, r_dividend[31]} - {1'b0, r_divisor};
  assign w_take      = ~w_trial[32];
  assign w_rem_step  = w_take ? w_trial[31:0] : {r_rem[30:0], r_dividend[31]};
  assign w_quot_step = {r_dividend[30:0], w_take};
  assign w_last      = (r_cnt == CW'(DIV_CYCLES - 1));

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_whilo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_div) begin
          w_stall      = 1'b1;
          w_state_next = (reg2_i == 32'h0) ? S_BY_ZERO : S_ON;
        end
      end
      S_BY_ZERO: begin
        w_stall      = 1'b1;
        w_state_next = S_DONE;
      end
      S_ON: begin
        w_stall = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_whilo      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_state_next = S_IDLE;
      w_stall      = 1'b0;
      w_whilo      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dividend <= 32'h0;
      r_divisor  <= 32'h0;
      r_rem      <= 32'h0;
      r_hi       <= 32'h0;
      r_lo       <= 32'h0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else if (!flush_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div && reg2_i != 32'h0) begin
            r_dividend <= w_abs1;
            r_divisor  <= w_abs2;
            r_rem      <= 32'h0;
            r_cnt      <= '0;
            r_neg_q    <= w_signed && (reg1_i[31] ^ reg2_i[31]);
            r_neg_r    <= w_signed && reg1_i[31];
          end
        end
        S_BY_ZERO: begin
          r_hi <= 32'h0;
          r_lo <= 32'h0;
        end
        S_ON: begin
          r_rem      <= w_rem_step;
          r_dividend <= w_quot_step;
          r_cnt      <= r_cnt + 1'b1;
          // Results land in hi/lo as DONE is entered and hold afterwards
          if (w_last) begin
            r_lo <= r_neg_q ? -w_quot_step : w_quot_step;
            r_hi <= r_neg_r ? -w_rem_step : w_rem_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign waddr_reg_o = rst ? 5'h0 : waddr_reg_i;
  assign we_reg_o    = rst ? 1'b0 : we_reg_i;
  assign wdata_o     = rst ? 32'h0 : w_wdata;
  assign whilo_o     = rst ? 1'b0 : w_whilo;
  assign stallreq_o  = rst ? 1'b0 : w_stall;
  assign hi_o        = rst ? 32'h0 : r_hi;
  assign lo_o        = rst ? 32'h0 : r_lo;

endmodule
